uart1rx: RTL and testbench

UART1RX -- requirements
Module: uart1rx

---
 rtl/uart1rx.sv | 201 ++++++++++++++++++++
 tb/tb_uart1rx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart1rx.sv
// uart1rx: 8N1 serial receiver with a 2-flop input synchronizer.
// The bit period is CLOCK_DIV clk cycles. The receiver samples each bit
// near its centre, then presents the byte on data with a ready/ack handshake.
// The handshake also reports frame_error and overrun.
// Optional build macro UART1RX_MAJORITY_EN: each sample becomes the 2-of-3
// majority of the synchronized line around the sample point. The decision is
// taken one cycle after the sample point.
module uart1rx #(
    parameter int CLOCK_DIV          = 8,
    parameter int CLOCK_COUNTER_BITS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       ready,
    input  logic       ack,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_ZERO = {CLOCK_COUNTER_BITS{1'b0}};
    localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_ONE  = CLOCK_COUNTER_BITS'(1);
    localparam logic [CLOCK_COUNTER_BITS-1:0] BIT_LOAD = CLOCK_COUNTER_BITS'(CLOCK_DIV - 1);
`ifdef UART1RX_MAJORITY_EN
    // Decision one cycle after the nominal mid-start sample point.
    localparam logic [CLOCK_COUNTER_BITS-1:0] START_LOAD = CLOCK_COUNTER_BITS'(CLOCK_DIV / 2);
`else
    localparam logic [CLOCK_COUNTER_BITS-1:0] START_LOAD = CLOCK_COUNTER_BITS'(CLOCK_DIV / 2 - 1);
`endif

`ifdef UART1RX_MAJORITY_EN
    // 2-of-3 vote used to reject single-cycle glitches on the line.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    logic                          sync1_r;
    logic                          sync2_r;
    logic                          prev_r;
    state_t                        state_r;
    state_t                        state_next_s;
    logic [CLOCK_COUNTER_BITS-1:0] cnt_r;
    logic [CLOCK_COUNTER_BITS-1:0] cnt_next_s;
    logic [2:0]                    idx_r;
    logic [2:0]                    idx_next_s;
    logic [7:0]                    shift_r;
    logic [7:0]                    shift_next_s;
    logic [7:0]                    data_r;
    logic                          ready_r;
    logic                          frame_error_r;
    logic                          overrun_r;
    logic                          busy_r;
    logic                          rx_s;
    logic                          fall_s;
    logic                          tick_s;
    logic                          sample_bit_s;
    logic                          complete_s;

    assign rx_s = sync2_r;
    // A start is recognised only on a seen-high to low transition. A stuck-low
    // (break) line therefore cannot retrigger until it has returned high.
    assign fall_s = prev_r & ~rx_s;
    assign tick_s = (cnt_r == CNT_ZERO);

`ifdef UART1RX_MAJORITY_EN
    logic [1:0] hist_r;

    // Two-deep history of the synchronized line feeding the majority vote.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_r <= 2'b11;
        end else begin
            hist_r <= {hist_r[0], rx_s};
        end
    end

    assign sample_bit_s = maj3(hist_r[1], hist_r[0], rx_s);
`else
    assign sample_bit_s = rx_s;
`endif

    assign data        = data_r;
    assign ready       = ready_r;
    assign frame_error = frame_error_r;
    assign overrun     = overrun_r;
    assign busy        = busy_r;

    // Input synchronizer and the previous-value flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Frame sequencer: next state, bit-period counter and shift register.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        shift_next_s = shift_r;
        complete_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_next_s = START;
                    cnt_next_s   = START_LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (!tick_s) begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end else if (!sample_bit_s) begin
                    state_next_s = DATA;
                    cnt_next_s   = BIT_LOAD;
                    idx_next_s   = 3'd0;
                end else begin
                    // The line was high at mid-start, so this is a false start.
                    state_next_s = IDLE;
                end
            end
            DATA: begin
                if (!tick_s) begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end else begin
                    shift_next_s = {sample_bit_s, shift_r[7:1]};
                    cnt_next_s   = BIT_LOAD;
                    if (idx_r == 3'd7) begin
                        state_next_s = STOP;
                    end else begin
                        idx_next_s = idx_r + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!tick_s) begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end else begin
                    complete_s   = 1'b1;
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // State/datapath registers and the consumer-facing output flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            cnt_r         <= CNT_ZERO;
            idx_r         <= 3'd0;
            shift_r       <= 8'h00;
            data_r        <= 8'h00;
            ready_r       <= 1'b0;
            frame_error_r <= 1'b0;
            overrun_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
            shift_r <= shift_next_s;
            busy_r  <= (state_next_s != IDLE);
            // A completing byte takes priority over a simultaneous ack.
            if (complete_s) begin
                data_r        <= shift_r;
                ready_r       <= 1'b1;
                frame_error_r <= ~sample_bit_s;
                overrun_r     <= ready_r & ~ack;
            end else if (ack) begin
                ready_r       <= 1'b0;
                frame_error_r <= 1'b0;
                overrun_r     <= 1'b0;
            end else begin
                ready_r <= ready_r;
            end
        end
    end

endmodule

// File: tb/tb_uart1rx.sv
// Scoreboard bench for uart1rx (CLOCK_DIV=8, CLOCK_COUNTER_BITS=4).
// Every frame end (busy falling) pops one expected {ready,data,frame_error,overrun}.
module tb_uart1rx;

    localparam int DIV = 8;
`ifdef UART1RX_MAJORITY_EN
    localparam int DONE_EDGE = 80;
`else
    localparam int DONE_EDGE = 79;
`endif
    localparam int LAT_BOUND = 2 + DIV / 2 + 9 * DIV + 1;

    typedef struct packed {
        logic       rdy;
        logic [7:0] d;
        logic       fe;
        logic       ov;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       ready;
    logic       ack;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    int   checks;
    int   failures;
    exp_t sb_q[$];

    uart1rx #(.CLOCK_DIV(DIV), .CLOCK_COUNTER_BITS(4)) dut (
        .clk(clk), .reset(reset), .rx(rx), .data(data), .ready(ready),
        .ack(ack), .frame_error(frame_error), .overrun(overrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: at each frame end compare DUT outputs with the next expected entry.
    initial begin
        logic busy_prev;
        exp_t e;
        exp_t act;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_prev = 1'b0;
            end else begin
                if (busy_prev && !busy) begin
                    checks++;
                    act = {ready, data, frame_error, overrun};
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_frame_end got rdy=%b data=%h fe=%b ov=%b",
                                 ready, data, frame_error, overrun);
                    end else begin
                        e = sb_q.pop_front();
                        if (act !== e) begin
                            failures++;
                            $display("FAIL frame got rdy=%b data=%h fe=%b ov=%b want rdy=%b data=%h fe=%b ov=%b",
                                     act.rdy, act.d, act.fe, act.ov, e.rdy, e.d, e.fe, e.ov);
                        end
                    end
                end
                busy_prev = busy;
            end
        end
    end

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic r, input logic [7:0] d, input logic fe, input logic ov);
        exp_t e;
        e.rdy = r;
        e.d   = d;
        e.fe  = fe;
        e.ov  = ov;
        sb_q.push_back(e);
    endtask

    // Serialize one 8N1 frame; optional 1-cycle glitch mid data bit glitch_bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_bit);
        @(posedge clk); #1 rx = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            if (i == glitch_bit) begin
                repeat (4) @(posedge clk);
                #1 rx = ~b[i];
                @(posedge clk);
                #1 rx = b[i];
                repeat (3) @(posedge clk);
            end else begin
                repeat (DIV) @(posedge clk);
            end
        end
        #1 rx = stop_bit;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] f0;
        int         cyc;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        rx       = 1'b1;
        ack      = 1'b0;
        f0       = 8'hF0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check1("rst_data", {24'd0, data}, 32'h00);
        check1("rst_ready", {31'd0, ready}, 32'd0);
        check1("rst_fe", {31'd0, frame_error}, 32'd0);
        check1("rst_ov", {31'd0, overrun}, 32'd0);
        check1("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        idle(5);

        // Two bytes with ack between, plus a latency bound on the first.
        expect_frame(1'b1, 8'h5A, 1'b0, 1'b0);
        cyc = 0;
        fork
            send_frame(8'h5A, 1'b1, -1);
            begin
                @(negedge rx);
                while (!ready && cyc < 200) begin
                    @(posedge clk); #1;
                    cyc++;
                end
            end
        join
        check1("latency_ready", {31'd0, ready}, 32'd1);
        check1("latency_le_bound", {31'd0, (cyc <= LAT_BOUND)}, 32'd1);
        pulse_ack();
        check1("ack_clears_ready", {31'd0, ready}, 32'd0);
        expect_frame(1'b1, 8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, -1);
        pulse_ack();
        idle(4);

        // 2-cycle false start, then a valid byte.
        expect_frame(1'b0, 8'hA5, 1'b0, 1'b0);
        @(posedge clk); #1 rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx = 1'b1;
        idle(20);
        check1("false_start_no_ready", {31'd0, ready}, 32'd0);
        expect_frame(1'b1, 8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, -1);
        pulse_ack();
        idle(4);

        // Low stop bit followed by a 20-bit break: exactly one error byte.
        expect_frame(1'b1, 8'h81, 1'b1, 1'b0);
        send_frame(8'h81, 1'b0, -1);
        idle(40);
        pulse_ack();
        check1("break_fe_cleared", {31'd0, frame_error}, 32'd0);
        idle(120);
        check1("break_no_ready", {31'd0, ready}, 32'd0);
        check1("break_not_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        idle(16);
        expect_frame(1'b1, 8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, -1);
        pulse_ack();
        idle(4);

        // Overrun: two bytes without ack.
        expect_frame(1'b1, 8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, -1);
        expect_frame(1'b1, 8'h22, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, -1);
        pulse_ack();
        check1("ovr_ack_ready", {31'd0, ready}, 32'd0);
        check1("ovr_ack_overrun", {31'd0, overrun}, 32'd0);
        idle(4);

        // ack lands on the STOP sample cycle while a previous byte is pending.
        expect_frame(1'b1, 8'h44, 1'b0, 1'b0);
        send_frame(8'h44, 1'b1, -1);
        expect_frame(1'b1, 8'h55, 1'b0, 1'b0);
        fork
            send_frame(8'h55, 1'b1, -1);
            begin
                @(negedge rx);
                repeat (DONE_EDGE - 1) @(posedge clk);
                #1 ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
            end
        join
        idle(2);
        check1("coincide_ready", {31'd0, ready}, 32'd1);
        check1("coincide_overrun", {31'd0, overrun}, 32'd0);
        check1("coincide_data", {24'd0, data}, 32'h55);
        pulse_ack();
        idle(4);

        // Reset during the 4th data bit of 0xF0, then receive 0x0F.
        @(posedge clk); #1 rx = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rx = f0[i];
            repeat (DIV) @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        rx = 1'b1;
        idle(2);
        check1("mid_rst_data", {24'd0, data}, 32'h00);
        check1("mid_rst_ready", {31'd0, ready}, 32'd0);
        check1("mid_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        idle(6);
        expect_frame(1'b1, 8'h0F, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b1, -1);
        pulse_ack();
        idle(4);

`ifdef UART1RX_MAJORITY_EN
        // Single-cycle glitch at the sample point of data bit 2 is voted out.
        expect_frame(1'b1, 8'h96, 1'b0, 1'b0);
        send_frame(8'h96, 1'b1, 2);
        pulse_ack();
        idle(4);
`endif

        idle(20);
        check1("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
